// File: rtl/data_mem_responder.sv
// Load/store memory responder: 1K x 32 array, fixed latency, valid/ready
// request and response handshakes, little-endian lanes, misalignment flag.
//
// Ports:
//   Clk, Rst (async active-low)
//   ReqValid/ReqReady, ReqWrite, ReqAddr, ReqSize, ReqSigned, ReqWData
//   RspValid/RspReady, RspRData, RspErr
module data_mem_responder #(
   parameter int ADDR_W  = 12,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [1:0]        ReqSize,
   input  logic              ReqSigned,
   input  logic [31:0]       ReqWData,
   output logic              RspValid,
   input  logic              RspReady,
   output logic [31:0]       RspRData,
   output logic              RspErr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;

   logic                r_write;
   logic                r_signed;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_size;
   logic [31:0]         r_wdata;

   logic [31:0]         r_mem [DEPTH];
   logic [31:0]         r_rdata;
   logic                r_err;

   logic                w_accept;
   logic                w_done;
   logic                w_err;
   logic [ADDR_W-3:0]   w_idx;
   logic [4:0]          w_shamt;
   logic [31:0]         w_word;
   logic [31:0]         w_sh;
   logic [31:0]         w_load;
   logic [31:0]         w_mask;
   logic [31:0]         w_merged;

   // Held low throughout reset, not just by the state register.
   assign ReqReady = Rst && (r_state == S_IDLE);
   assign RspValid = (r_state == S_RESP);
   assign RspRData = r_rdata;
   assign RspErr   = r_err;

   assign w_accept = ReqValid && ReqReady;
   assign w_done   = (r_state == S_WAIT) && (r_cnt == 4'd0);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = 4'(LATENCY - 1);
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         S_RESP: begin
            if (RspReady) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_write  <= 1'b0;
         r_signed <= 1'b0;
         r_addr   <= '0;
         r_size   <= 2'b00;
         r_wdata  <= 32'h0;
      end else if (w_accept) begin
         r_write  <= ReqWrite;
         r_signed <= ReqSigned;
         r_addr   <= ReqAddr;
         r_size   <= ReqSize;
         r_wdata  <= ReqWData;
      end
   end

   assign w_err = (r_size == 2'b11)
               || ((r_size == 2'b00) && (r_addr[1:0] != 2'b00))
               || ((r_size == 2'b01) && r_addr[0]);

   assign w_idx   = r_addr[ADDR_W-1:2];
   assign w_shamt = {r_addr[1:0], 3'b000};
   assign w_word  = r_mem[w_idx];
   assign w_sh    = w_word >> w_shamt;

   always_comb begin
      w_load = 32'h0;
      w_mask = 32'h0;
      unique case (r_size)
         2'b00: begin
            w_load = w_word;
            w_mask = 32'hFFFF_FFFF;
         end
         2'b01: begin
            w_load = {{16{r_signed & w_sh[15]}}, w_sh[15:0]};
            w_mask = 32'h0000_FFFF << w_shamt;
         end
         2'b10: begin
            w_load = {{24{r_signed & w_sh[7]}}, w_sh[7:0]};
            w_mask = 32'h0000_00FF << w_shamt;
         end
         default: begin
            w_load = 32'h0;
            w_mask = 32'h0;
         end
      endcase
   end

   // Read-modify-write keeps the unaddressed lanes intact.
   assign w_merged = (w_word & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

   always_ff @(posedge Clk) begin
      if (w_done && r_write && !w_err) r_mem[w_idx] <= w_merged;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else if (w_done) begin
         r_err   <= w_err;
         r_rdata <= (w_err || r_write) ? 32'h0 : w_load;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (LATENCY=2): handshake timing,
// lane merge/extension, misalignment, backpressure, mid-flight reset.
module tb_data_mem_responder;

   logic        Clk;
   logic        Rst;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [11:0] ReqAddr;
   logic [1:0]  ReqSize;
   logic        ReqSigned;
   logic [31:0] ReqWData;
   logic        RspValid;
   logic        RspReady;
   logic [31:0] RspRData;
   logic        RspErr;

   int n_chk;
   int n_pass;

   data_mem_responder #(
      .ADDR_W (12),
      .DEPTH  (1024),
      .LATENCY(2)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .ReqValid (ReqValid),
      .ReqReady (ReqReady),
      .ReqWrite (ReqWrite),
      .ReqAddr  (ReqAddr),
      .ReqSize  (ReqSize),
      .ReqSigned(ReqSigned),
      .ReqWData (ReqWData),
      .RspValid (RspValid),
      .RspReady (RspReady),
      .RspRData (RspRData),
      .RspErr   (RspErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic set_req(input logic wr, input logic [11:0] a,
                          input logic [1:0] sz, input logic sg,
                          input logic [31:0] wd);
      ReqValid  = 1'b1;
      ReqWrite  = wr;
      ReqAddr   = a;
      ReqSize   = sz;
      ReqSigned = sg;
      ReqWData  = wd;
   endtask

   // Called #1 after an edge with the responder idle.
   task automatic do_req(input string tag, input logic wr,
                         input logic [11:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e);
      RspReady = 1'b1;
      set_req(wr, a, sz, sg, wd);
      chk({tag, "_rdy"}, 32'(ReqReady), 32'd1);
      @(posedge Clk); #1;
      ReqValid = 1'b0;
      ReqAddr  = ~a;
      ReqWData = ~wd;
      ReqWrite = ~wr;
      chk({tag, "_busy1"}, {30'd0, ReqReady, RspValid}, 32'd0);
      @(posedge Clk); #1;
      chk({tag, "_busy2"}, {30'd0, ReqReady, RspValid}, 32'd0);
      @(posedge Clk); #1;
      chk({tag, "_vld"}, {30'd0, ReqReady, RspValid}, 32'd1);
      chk({tag, "_data"}, RspRData, exp_d);
      chk({tag, "_err"}, 32'(RspErr), 32'(exp_e));
      @(posedge Clk); #1;
      chk({tag, "_idle"}, {30'd0, ReqReady, RspValid}, 32'd2);
   endtask

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      Rst       = 1'b0;
      ReqValid  = 1'b0;
      ReqWrite  = 1'b0;
      ReqAddr   = '0;
      ReqSize   = 2'b00;
      ReqSigned = 1'b0;
      ReqWData  = 32'h0;
      RspReady  = 1'b1;

      #3;
      chk("rst_out", {ReqReady, RspValid, RspErr, 29'd0} | RspRData, 32'd0);
      #19 Rst = 1'b1;
      @(posedge Clk); #1;
      chk("rst_rel_rdy", 32'(ReqReady), 32'd1);

      do_req("st_w",   1, 12'h010, 2'b00, 0, 32'hDEADBEEF, 32'h0, 0);
      do_req("ld_w",   0, 12'h010, 2'b00, 0, 32'h0, 32'hDEADBEEF, 0);
      do_req("st_b",   1, 12'h013, 2'b10, 0, 32'hFFFF_FF80, 32'h0, 0);
      do_req("ld_wb",  0, 12'h010, 2'b00, 1, 32'h0, 32'h80ADBEEF, 0);
      do_req("ld_bs",  0, 12'h013, 2'b10, 1, 32'h0, 32'hFFFFFF80, 0);
      do_req("ld_bu",  0, 12'h013, 2'b10, 0, 32'h0, 32'h00000080, 0);
      do_req("ld_hs",  0, 12'h012, 2'b01, 1, 32'h0, 32'hFFFF80AD, 0);
      do_req("ld_hu0", 0, 12'h010, 2'b01, 0, 32'h0, 32'h0000BEEF, 0);
      do_req("ld_b1",  0, 12'h011, 2'b10, 1, 32'h0, 32'hFFFFFFBE, 0);
      do_req("ld_mis", 0, 12'h011, 2'b00, 0, 32'h0, 32'h0, 1);
      do_req("st_mis", 1, 12'h011, 2'b00, 0, 32'h0, 32'h0, 1);
      do_req("st_hmis",1, 12'h013, 2'b01, 0, 32'h1111, 32'h0, 1);
      do_req("st_rsv", 1, 12'h010, 2'b11, 0, 32'h0, 32'h0, 1);
      do_req("ld_chk", 0, 12'h010, 2'b00, 0, 32'h0, 32'h80ADBEEF, 0);

      // Backpressure: response held, new request waits for IDLE.
      RspReady = 1'b0;
      set_req(0, 12'h010, 2'b00, 0, 32'h0);
      @(posedge Clk); #1;
      set_req(0, 12'h013, 2'b10, 0, 32'h0);
      @(posedge Clk);
      @(posedge Clk); #1;
      chk("bp_vld", 32'(RspValid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge Clk); #1;
         chk("bp_hold", {29'd0, ReqReady, RspValid, RspErr}, 32'd2);
         chk("bp_data", RspRData, 32'h80ADBEEF);
      end
      RspReady = 1'b1;
      @(posedge Clk); #1;
      chk("bp_rel", {30'd0, ReqReady, RspValid}, 32'd2);
      @(posedge Clk); #1;
      chk("bp_acc", 32'(ReqReady), 32'd0);
      ReqValid = 1'b0;
      @(posedge Clk);
      @(posedge Clk); #1;
      chk("bp2_vld", 32'(RspValid), 32'd1);
      chk("bp2_data", RspRData, 32'h00000080);
      @(posedge Clk); #1;

      // Reset during WAIT drops the store.
      do_req("st_pre", 1, 12'h020, 2'b00, 0, 32'h11111111, 32'h0, 0);
      set_req(1, 12'h020, 2'b00, 0, 32'h12345678);
      @(posedge Clk); #1;
      ReqValid = 1'b0;
      Rst = 1'b0;
      #1;
      chk("rw_out", {30'd0, ReqReady, RspValid}, 32'd0);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk("rw_rdy", 32'(ReqReady), 32'd1);
      do_req("rw_rb", 0, 12'h020, 2'b00, 0, 32'h0, 32'h11111111, 0);

      // Reset during RESP of a load clears response outputs at once.
      RspReady = 1'b0;
      set_req(0, 12'h010, 2'b00, 0, 32'h0);
      @(posedge Clk); #1;
      ReqValid = 1'b0;
      @(posedge Clk);
      @(posedge Clk); #1;
      chk("rl_vld", RspRData, 32'h80ADBEEF);
      Rst = 1'b0;
      #1;
      chk("rl_clr", {RspValid, RspErr, ReqReady, 29'd0} | RspRData, 32'd0);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk); #1;

      // Reset during RESP of a store keeps the commit.
      set_req(1, 12'h020, 2'b00, 0, 32'h12345678);
      @(posedge Clk); #1;
      ReqValid = 1'b0;
      @(posedge Clk);
      @(posedge Clk); #1;
      chk("rr_vld", 32'(RspValid), 32'd1);
      Rst = 1'b0;
      #1;
      chk("rr_clr", {RspValid, RspErr, ReqReady, 29'd0} | RspRData, 32'd0);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk("rr_rdy", 32'(ReqReady), 32'd1);
      do_req("rr_rb", 0, 12'h020, 2'b00, 0, 32'h0, 32'h12345678, 0);

      // Upper half lane store.
      do_req("st_h2", 1, 12'h022, 2'b01, 0, 32'h0000CAFE, 32'h0, 0);
      do_req("ld_w2", 0, 12'h020, 2'b00, 0, 32'h0, 32'hCAFE5678, 0);
      do_req("ld_hu2",0, 12'h022, 2'b01, 0, 32'h0, 32'h0000CAFE, 0);
      do_req("ld_b0", 0, 12'h020, 2'b10, 1, 32'h0, 32'h00000078, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
